// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM encoding, access-size codes, default timeout.
// The optional access watchdog is enabled by defining ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: counts ACCESS cycles without acknowledge; built only when ARB_TIMEOUT_EN is defined.
// expired is asserted during the LIMIT-th waiting cycle so the abort lands on that cycle's edge.
module arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (LIMIT > 255) ? $clog2(LIMIT + 1) : 8;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single acknowledge-based memory bus.
// Define ARB_TIMEOUT_EN to build the access watchdog (parameter TIMEOUT) and the err output.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
`ifdef ARB_TIMEOUT_EN
  #(parameter int TIMEOUT = DEFAULT_TIMEOUT)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] m_addr,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_wdata,
  output logic        m_oe,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic        err
);

  state_t state;
  logic   last_d;
  logic   gnt_d;
  logic   any_req;
  logic   pick_d;
  logic   ack;
  logic   abort;

  // On a tie the port not served last wins, giving strict alternation.
  always_comb begin
    any_req = i_req | d_req;
    pick_d  = d_req & (~i_req | ~last_d);
    ack     = ~m_ack_n;
  end

`ifdef ARB_TIMEOUT_EN
  logic expired;

  arb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == ST_IDLE) && any_req),
    .run     ((state == ST_ACCESS) && m_ack_n),
    .expired (expired)
  );

  assign abort = expired;
`else
  assign abort = 1'b0;
`endif

  assign m_oe = m_req & m_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last_d  <= 1'b0;
      gnt_d   <= 1'b0;
      m_addr  <= '0;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= SIZE_WORD;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_ACCESS;
            m_req <= 1'b1;
            gnt_d <= pick_d;
            if (pick_d) begin
              m_addr  <= d_addr;
              m_write <= d_we;
              m_size  <= d_size;
              m_wdata <= d_wdata;
            end else begin
              m_addr  <= i_addr;
              m_write <= 1'b0;
              m_size  <= SIZE_WORD;
              m_wdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the same cycle as the watchdog limit completes normally.
          if (ack || abort) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            m_write <= 1'b0;
            last_d  <= gnt_d;
            err     <= ~ack;
            if (gnt_d) begin
              d_rdata <= ack ? m_rdata : '0;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= ack ? m_rdata : '0;
              i_done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; grant order comes from a last-served model.
// Watchdog checks switch on when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] m_addr;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_oe;
  logic [31:0] m_rdata;
  logic        m_ack_n;
  logic        err;

  int checks = 0;
  int fails  = 0;
  bit model_last_d = 1'b0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  mem_port_arbiter #(.TIMEOUT(4)) dut (
`else
  mem_port_arbiter dut (
`endif
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .m_addr(m_addr), .m_req(m_req), .m_write(m_write), .m_size(m_size),
    .m_wdata(m_wdata), .m_oe(m_oe), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after the grant edge; leaves at the negedge of the done cycle.
  task automatic serve(input bit own_d, input logic [31:0] addr, input bit we,
                       input logic [1:0] size, input logic [31:0] wdata, input int w,
                       input logic [31:0] rd, input bit drop_i, input bit drop_d);
    logic       exp_wr;
    logic [1:0] exp_size;
    exp_wr   = own_d & we;
    exp_size = own_d ? size : 2'b00;
    @(negedge clk);
    chk("m_req_grant", m_req, 1);
    chk("m_addr", m_addr, addr);
    chk("m_write", m_write, exp_wr);
    chk("m_size", m_size, exp_size);
    chk("m_oe", m_oe, exp_wr);
    if (own_d) chk("m_wdata", m_wdata, wdata);
    chk("done_idle", {i_done, d_done}, 0);
    for (int j = 1; j < w; j++) begin
      @(negedge clk);
      chk("m_req_hold", m_req, 1);
      chk("m_addr_hold", m_addr, addr);
      chk("m_write_hold", m_write, exp_wr);
      chk("m_size_hold", m_size, exp_size);
      chk("done_wait", {i_done, d_done}, 0);
    end
    m_ack_n = 1'b0;
    m_rdata = rd;
    @(posedge clk);
    #1;
    m_ack_n = 1'b1;
    m_rdata = $urandom;
    if (drop_i) i_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    @(negedge clk);
    chk("i_done", i_done, !own_d);
    chk("d_done", d_done, own_d);
    chk("err_normal", err, 0);
    chk("m_req_drop", m_req, 0);
    chk("m_oe_drop", m_oe, 0);
    if (!(own_d && we)) chk(own_d ? "d_rdata" : "i_rdata", own_d ? d_rdata : i_rdata, rd);
    model_last_d = own_d;
  endtask

  task automatic serve_port(input bit own_d, input int w, input bit drop_i, input bit drop_d);
    serve(own_d, own_d ? d_addr : i_addr, d_we, d_size, d_wdata, w, $urandom, drop_i, drop_d);
  endtask

  initial begin
    bit first_d;
    int mode;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'b00; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;

    // Reset state
    tick;
    tick;
    @(negedge clk);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_dones", {i_done, d_done, err}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_strobes", {m_req, m_write, m_oe}, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_m_wdata", m_wdata, 0);

    // Single fetch, ack on first ACCESS cycle
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_addr = 32'h0001_0000;
    i_req = 1'b1;
    tick;
    serve(1'b0, 32'h0001_0000, 1'b0, 2'b00, 32'h0, 1, 32'h0050_0093, 1'b1, 1'b0);
    tick;

    // Tie: data wins first, then strict alternation while both hold
    i_addr = 32'h0000_0100;
    d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_size = 2'b10;
    i_req = 1'b1; d_req = 1'b1;
    tick;
    chk("tie_model_data_first", model_last_d, 0);
    for (int n = 0; n < 4; n++) begin
      serve_port(!model_last_d, 1 + n, n == 3, n == 3);
      tick;
    end

    // Load with five wait states
    d_we = 1'b0; d_addr = 32'h0000_3000; d_size = 2'b00; d_wdata = $urandom;
    d_req = 1'b1;
    tick;
    serve(1'b1, 32'h0000_3000, 1'b0, 2'b00, d_wdata, 6, 32'hCAFE_0001, 1'b0, 1'b1);
    tick;

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      mode    = $urandom_range(0, 2);
      i_addr  = $urandom & 32'hFFFF_FFFC;
      d_addr  = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      d_size  = 2'($urandom_range(0, 2));
      d_wdata = $urandom;
      i_req   = (mode != 1);
      d_req   = (mode != 0);
      tick;
      if (mode == 2) begin
        first_d = !model_last_d;
        serve_port(first_d, $urandom_range(1, 4), !first_d, first_d);
        tick;
        serve_port(!first_d, $urandom_range(1, 4), first_d, !first_d);
      end else begin
        serve_port(mode == 1, $urandom_range(1, 4), 1'b1, 1'b1);
      end
      tick;
    end

    // Reset on the 3rd ACCESS cycle, late ack ignored
    d_we = 1'b0; d_addr = 32'h0000_4000; d_size = 2'b00;
    d_req = 1'b1;
    tick;
    @(negedge clk);
    chk("rmid_m_req_c1", m_req, 1);
    @(negedge clk);
    chk("rmid_m_req_c2", m_req, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ack_n = 1'b0;
    m_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("rmid_m_req_after", m_req, 0);
    chk("rmid_no_done", {i_done, d_done}, 0);
    @(posedge clk);
    #1;
    m_ack_n = 1'b1;
    @(negedge clk);
    chk("rmid_late_ack_done", {i_done, d_done, err}, 0);
    chk("rmid_late_ack_m_req", m_req, 0);
    chk("rmid_d_rdata", d_rdata, 0);
    model_last_d = 1'b0;

    // After reset the tie again goes to data
    i_addr = 32'h0000_0200; d_addr = 32'h0000_0300; d_we = 1'b0; d_size = 2'b01;
    i_req = 1'b1; d_req = 1'b1;
    tick;
    serve_port(1'b1, 2, 1'b0, 1'b1);
    tick;
    serve_port(1'b0, 1, 1'b1, 1'b0);
    tick;

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort after 4 ACCESS cycles
    d_we = 1'b0; d_addr = 32'h0000_5000; d_size = 2'b00;
    d_req = 1'b1;
    tick;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("to_m_req_wait", m_req, 1);
      chk("to_no_done", {d_done, err}, 0);
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("to_d_done", d_done, 1);
    chk("to_err", err, 1);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_m_req", m_req, 0);
    tick;
    // Ack on the limit cycle completes normally
    d_req = 1'b1;
    tick;
    serve_port(1'b1, 4, 1'b0, 1'b1);
    tick;
`else
    // No watchdog: access waits indefinitely
    d_we = 1'b0; d_addr = 32'h0000_5000; d_size = 2'b00;
    d_req = 1'b1;
    tick;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      chk("nto_m_req", m_req, 1);
      chk("nto_err_done", {err, d_done}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_req = 1'b0;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("nto_rst_m_req", m_req, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one external memory bus between the core's instruction-fetch port and its load/store data port. Each requester holds a request with its address and attributes. The arbiter grants one access at a time, drives the memory-side strobes, waits for the memory's active-low acknowledge, then returns read data with a one-cycle done pulse. It sits between the processor core and the system memory bus.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles before abort; used only when the timeout feature is compiled in.
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  32  fetch address; stable while i_req is high.
- i_rdata  out  32  fetched instruction; valid while i_done is high, then held.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 word, 01 half, 10 byte.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_done is high, then held.
- d_done  out  1  one-cycle completion pulse for data.
- m_addr  out  32  memory address (registered).
- m_req  out  1  memory request strobe (registered).
- m_write  out  1  memory write strobe (registered).
- m_size  out  2  access size; fetches always use 00.
- m_wdata  out  32  store data (registered).
- m_oe  out  1  equals m_req & m_write; enables the top-level tristate driver on the bidirectional data bus.
- m_rdata  in  32  memory read data; valid in the same cycle m_ack_n is low.
- m_ack_n  in  1  active-low acknowledge from memory.
- err  out  1  pulses together with a done pulse when that access timed out.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, neither request pending: stay in IDLE; all memory strobes low.
- IDLE, one request pending: grant it on the next edge.
- IDLE, both requests pending: grant the port *not* served last.
  - last_d flag; reset value 0, so data wins the first tie.
  - Result: strict alternation while both ports keep requesting.
- Grant edge latches the following from the granted port:
  - m_addr, m_write (d_we for data, 0 for fetch), m_size, m_wdata.
  - gnt_d, which records the owner of the access.
- Grant edge also sets m_req=1 and moves to ACCESS.
- ACCESS, m_ack_n=1: hold every memory output unchanged.
- ACCESS, m_ack_n=0 at an edge:
  - capture m_rdata into the owner's rdata register (stores capture too; the value is don't-care);
  - pulse the owner's done on the next cycle;
  - drop m_req and m_write;
  - update last_d;
  - return to IDLE.
- Done cycle:
  - The FSM is already in IDLE.
  - A req still high in this cycle is a new request and can be granted at the next edge (back-to-back accesses).
  - A requester wanting only one access must drop req in its done cycle.
- Requests that arrive while in ACCESS wait; they are never lost.
- m_ack_n low while in IDLE is ignored.

## Timing
- Reset values: every output 0, state IDLE, last_d 0.
- rst mid-ACCESS:
  - the access is abandoned and no done pulse is issued;
  - m_req is 0 in the cycle after the rst edge;
  - an ack arriving later is ignored.
- Latency from req high at IDLE edge k:
  - m_req is high during cycles k+1 … k+W, where W is the number of ACCESS cycles up to and including the ack cycle (W ≥ 1);
  - done is high in cycle k+W+1.
- Minimum latency (ack in the first ACCESS cycle): done 2 cycles after req is sampled.
- Throughput: at most one access every 2 cycles.

## Configuration
- ARB_TIMEOUT_EN defined:
  - an 8-bit-or-wider counter clears on grant and increments each ACCESS cycle without ack;
  - when the counter reaches TIMEOUT, the access is aborted: m_req drops, the owner's done and err pulse together, and the owner's rdata is set to 0;
  - an ack in the same cycle as the limit wins: normal completion, err stays 0.
- ARB_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely for ack;
  - err is tied to 0 and no counter logic is built;
  - TIMEOUT is ignored.

## Structure
- Shared header holds:
  - FSM state encodings;
  - SIZE codes (word 2'b00, half 2'b01, byte 2'b10);
  - the default TIMEOUT value.
- One sub-module, arb_watchdog:
  - ports: clk, rst, clear, run, expired; parameter LIMIT;
  - instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Reset check: rst for 2 cycles → all outputs 0. Then i_req with i_addr=0x10000, memory acks on the first ACCESS cycle with m_rdata=0x00500093 → m_addr=0x10000 and m_size=00; i_done high 2 cycles after req; i_rdata=0x00500093.
- Tie, then alternation: i_req and d_req raised together, with d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=10 → data granted first with m_write=1, m_oe=1, m_size=10; fetch granted immediately after d_done; both ports held high → grants strictly alternate D, I, D, I.
- Wait states: memory delays ack by 5 cycles on a load from 0x3000 → m_* outputs stable for 6 cycles; d_done in cycle k+7; d_rdata equals m_rdata in the ack cycle.
- Reset mid-access: rst asserted on the 3rd ACCESS cycle, ack follows 1 cycle later → no done pulse; state IDLE; m_req=0.
- Timeout, built with ARB_TIMEOUT_EN and TIMEOUT=4, memory never acks → d_done=1, err=1, d_rdata=0, one cycle after the 4th ACCESS cycle. Built without the macro → m_req stays high for 100+ cycles and err stays 0.
